// File: rtl/multi_fifo_rr_merge.sv
// Per-channel circular FIFOs merged onto one output (round-robin or fixed priority); head visible one cycle after push.
// Pushes into a full channel are dropped; the consumer paces the merge with pop_i against valid_o.
module multi_fifo_rr_merge #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int PRIO_MODE  = 0,
  localparam int CW = $clog2(CHANNELS),
  localparam int UW = $clog2(DEPTH) + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [CHANNELS-1:0]            flush_i,
  input  logic [CHANNELS-1:0]            push_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_i,
  output logic [CHANNELS-1:0]            full_o,
  output logic [CHANNELS-1:0]            empty_o,
  output logic [CHANNELS*UW-1:0]         usage_o,
  output logic                           valid_o,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic [CW-1:0]                  sel_o,
  input  logic                           pop_i
);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem    [CHANNELS][DEPTH];
  logic [PW-1:0]         rd_ptr [CHANNELS];
  logic [PW-1:0]         wr_ptr [CHANNELS];
  logic [UW-1:0]         count  [CHANNELS];
  logic [CW-1:0]         last_q;
  logic [CW-1:0]         sel;
  logic [CW-1:0]         cand;
  logic                  found;
  logic [CHANNELS-1:0]   nonempty;
  logic [CHANNELS-1:0]   push_ok;
  logic [CHANNELS-1:0]   pop_ch;

  // Status flags come only from registered counts.
  always_comb begin
    full_o   = '0;
    empty_o  = '0;
    usage_o  = '0;
    nonempty = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      full_o[c]            = (count[c] == UW'(DEPTH));
      empty_o[c]           = (count[c] == '0);
      nonempty[c]          = (count[c] != '0);
      usage_o[c*UW +: UW]  = count[c];
    end
  end

  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      if (PRIO_MODE != 0) cand = CW'(k - 1);
      else                cand = CW'((int'(last_q) + k) % CHANNELS);
      if (!found && nonempty[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign valid_o = |nonempty;
  assign sel_o   = sel;
  assign data_o  = valid_o ? mem[sel][rd_ptr[sel]] : '0;

  always_comb begin
    push_ok = '0;
    pop_ch  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      push_ok[c] = push_i[c] && !full_o[c];
      pop_ch[c]  = pop_i && valid_o && (sel == CW'(c));
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (push_ok[c] && !flush_i[c]) mem[c][wr_ptr[c]] <= data_i[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= CW'(CHANNELS - 1);
      for (int c = 0; c < CHANNELS; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      // A flushed channel still counts as the last served one.
      if (pop_i && valid_o) last_q <= sel;
      for (int c = 0; c < CHANNELS; c++) begin
        if (flush_i[c]) begin
          rd_ptr[c] <= '0;
          wr_ptr[c] <= '0;
          count[c]  <= '0;
        end else begin
          if (push_ok[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
          if (pop_ch[c])  rd_ptr[c] <= rd_ptr[c] + PW'(1);
          if (push_ok[c] && !pop_ch[c])      count[c] <= count[c] + UW'(1);
          else if (!push_ok[c] && pop_ch[c]) count[c] <= count[c] - UW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_fifo_rr_merge.sv
// Directed bench for multi_fifo_rr_merge: round-robin and fixed-priority instances share stimulus,
// each checked every cycle against per-channel scoreboard queues.
module tb_multi_fifo_rr_merge;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   flush, push;
  logic         pop;
  logic [127:0] din;

  logic [3:0]  r_full, r_empty, p_full, p_empty;
  logic [15:0] r_usage, p_usage;
  logic        r_valid, p_valid;
  logic [31:0] r_data, p_data;
  logic [1:0]  r_sel, p_sel;

  int n_asserts = 0;
  int n_fails   = 0;

  logic [31:0] mq [8][$];
  int          mlast [2];

  always #5 clk = ~clk;

  multi_fifo_rr_merge #(.DATA_WIDTH(32), .DEPTH(8), .CHANNELS(4), .PRIO_MODE(0)) u_rr (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .data_i(din),
    .full_o(r_full), .empty_o(r_empty), .usage_o(r_usage), .valid_o(r_valid),
    .data_o(r_data), .sel_o(r_sel), .pop_i(pop));

  multi_fifo_rr_merge #(.DATA_WIDTH(32), .DEPTH(8), .CHANNELS(4), .PRIO_MODE(1)) u_prio (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .data_i(din),
    .full_o(p_full), .empty_o(p_empty), .usage_o(p_usage), .valid_o(p_valid),
    .data_o(p_data), .sel_o(p_sel), .pop_i(pop));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] dat(input logic [31:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  function automatic int msel(input int m);
    int idx;
    if (m == 1) begin
      for (int c = 0; c < 4; c++) if (mq[4 + c].size() != 0) return c;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = (mlast[0] + k) % 4;
        if (mq[idx].size() != 0) return idx;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mq[i].delete();
    mlast[0] = 3;
    mlast[1] = 3;
  endtask

  task automatic check_inst(input int m, input logic v, input logic [1:0] s, input logic [31:0] d,
                            input logic [3:0] f, input logic [3:0] e, input logic [15:0] u);
    logic        ev;
    logic [3:0]  ef, ee;
    logic [15:0] eu;
    logic [31:0] ed;
    int          es, n;
    string       nm;
    nm = (m == 0) ? "rr" : "prio";
    ev = 1'b0; ef = '0; ee = '0; eu = '0;
    for (int c = 0; c < 4; c++) begin
      n = mq[m*4 + c].size();
      eu[c*4 +: 4] = 4'(n);
      ef[c] = (n == 8);
      ee[c] = (n == 0);
      if (n != 0) ev = 1'b1;
    end
    es = ev ? msel(m) : 0;
    ed = ev ? mq[m*4 + es][0] : 32'h0;
    chk({nm, " valid"}, 32'(v), 32'(ev));
    chk({nm, " sel"},   32'(s), 32'(es));
    chk({nm, " data"},  d, ed);
    chk({nm, " full"},  32'(f), 32'(ef));
    chk({nm, " empty"}, 32'(e), 32'(ee));
    chk({nm, " usage"}, 32'(u), 32'(eu));
  endtask

  task automatic model_update(input logic r, input logic [3:0] fl, input logic [3:0] pu,
                              input logic po, input logic [127:0] d);
    logic       v;
    int         s;
    logic [3:0] was_full;
    if (r) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      v = 1'b0;
      for (int c = 0; c < 4; c++) begin
        was_full[c] = (mq[m*4 + c].size() == 8);
        if (mq[m*4 + c].size() != 0) v = 1'b1;
      end
      s = msel(m);
      if (po && v) mlast[m] = s;
      for (int c = 0; c < 4; c++) begin
        if (fl[c]) mq[m*4 + c].delete();
        else begin
          if (po && v && s == c) void'(mq[m*4 + c].pop_front());
          if (pu[c] && !was_full[c]) mq[m*4 + c].push_back(d[c*32 +: 32]);
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] fl, input logic [3:0] pu,
                      input logic po, input logic [127:0] d);
    @(negedge clk);
    rst = r; flush = fl; push = pu; pop = po; din = d;
    #1;
    check_inst(0, r_valid, r_sel, r_data, r_full, r_empty, r_usage);
    check_inst(1, p_valid, p_sel, p_data, p_full, p_empty, p_usage);
    model_update(r, fl, pu, po, d);
    @(posedge clk);
    #1;
    rst = 1'b0; flush = '0; push = '0; pop = 1'b0; din = '0;
  endtask

  task automatic exp_reset_outputs(input string tag);
    chk({tag, " rr valid"},  32'(r_valid), 32'h0);
    chk({tag, " rr sel"},    32'(r_sel),   32'h0);
    chk({tag, " rr data"},   r_data,       32'h0);
    chk({tag, " rr empty"},  32'(r_empty), 32'hF);
    chk({tag, " rr full"},   32'(r_full),  32'h0);
    chk({tag, " rr usage"},  32'(r_usage), 32'h0);
    chk({tag, " prio valid"}, 32'(p_valid), 32'h0);
    chk({tag, " prio empty"}, 32'(p_empty), 32'hF);
  endtask

  initial begin
    // Reset with every other input active; none of it may leave a trace.
    rst = 1'b1; flush = '0; push = 4'hF; pop = 1'b1;
    din = dat(32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; push = '0; pop = 1'b0; din = '0;
    model_reset();
    exp_reset_outputs("reset");

    // Two channels pushed in the same cycle, then drained.
    step(0, 4'h0, 4'b0101, 0, dat(32'hA0, 0, 32'hB0, 0));
    chk("basic first sel",  32'(r_sel), 32'd0);
    chk("basic first data", r_data,     32'hA0);
    step(0, 4'h0, 4'h0, 1, '0);
    chk("basic second sel",  32'(r_sel), 32'd2);
    chk("basic second data", r_data,     32'hB0);
    step(0, 4'h0, 4'h0, 1, '0);
    chk("basic drained valid", 32'(r_valid), 32'd0);
    step(0, 4'h0, 4'h0, 1, '0);  // pop while empty is ignored

    // Fill ch1, overflow push with simultaneous pop, drain across the wrap.
    for (int i = 0; i < 8; i++) step(0, 4'h0, 4'b0010, 0, dat(0, 32'h10 + 32'(i), 0, 0));
    chk("fill full",  32'(r_full), 32'b0010);
    chk("fill usage", 32'(r_usage[7:4]), 32'd8);
    step(0, 4'h0, 4'b0010, 1, dat(0, 32'h18, 0, 0));
    chk("overflow usage", 32'(r_usage[7:4]), 32'd7);
    for (int i = 1; i < 8; i++) begin
      chk("drain data", r_data, 32'h10 + 32'(i));
      step(0, 4'h0, 4'h0, 1, '0);
    end
    chk("drain empty", 32'(r_empty), 32'hF);

    // Round-robin fairness across four loaded channels.
    step(1, 4'h0, 4'h0, 0, '0);
    for (int i = 0; i < 3; i++)
      step(0, 4'h0, 4'hF, 0, dat(32'h00 + 32'(i), 32'h10 + 32'(i), 32'h20 + 32'(i), 32'h30 + 32'(i)));
    for (int i = 0; i < 12; i++) begin
      chk("rr order", 32'(r_sel), 32'(i % 4));
      step(0, 4'h0, 4'h0, 1, '0);
    end

    // Fixed priority keeps serving ch0 while it is refilled.
    step(1, 4'h0, 4'h0, 0, '0);
    for (int i = 0; i < 2; i++) step(0, 4'h0, 4'b1001, 0, dat(32'h40 + 32'(i), 0, 0, 32'h70 + 32'(i)));
    for (int i = 0; i < 4; i++) begin
      chk("prio hold ch0", 32'(p_sel), 32'd0);
      step(0, 4'h0, 4'b0001, 1, dat(32'h50 + 32'(i), 0, 0, 0));
    end
    for (int i = 0; i < 2; i++) begin
      chk("prio drain ch0", 32'(p_sel), 32'd0);
      step(0, 4'h0, 4'h0, 1, '0);
    end
    chk("prio then ch3 sel",  32'(p_sel), 32'd3);
    chk("prio then ch3 data", p_data,     32'h70);

    // Flush of the channel being popped, with a push that must be dropped.
    step(1, 4'h0, 4'h0, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 4'h0, 4'b0100, 0, dat(0, 0, 32'h60 + 32'(i), 0));
    chk("flush pre sel", 32'(r_sel), 32'd2);
    step(0, 4'b0100, 4'b0100, 1, dat(0, 0, 32'h6F, 0));
    chk("flush usage", 32'(r_usage[11:8]), 32'd0);
    chk("flush empty", 32'(r_empty[2]),    32'd1);
    step(0, 4'h0, 4'b1010, 0, dat(0, 32'h81, 0, 32'h83));
    chk("flush last_q follows popped ch2", 32'(r_sel), 32'd3);

    // Reset mid-operation with entries queued and pop asserted.
    step(0, 4'h0, 4'b0011, 0, dat(32'h90, 32'h91, 0, 0));
    step(0, 4'h0, 4'b0011, 0, dat(32'h92, 32'h93, 0, 0));
    step(1, 4'h0, 4'h0, 1, '0);
    exp_reset_outputs("midreset");
    step(0, 4'h0, 4'b0011, 0, dat(32'hA5, 32'hA6, 0, 0));
    chk("post reset sel",  32'(r_sel), 32'd0);
    chk("post reset data", r_data,     32'hA5);
    step(0, 4'h0, 4'h0, 1, '0);
    step(0, 4'h0, 4'h0, 1, '0);
    step(0, 4'h0, 4'h0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule

// File: doc/multi_fifo_rr_merge.md
MULTI_FIFO_RR_MERGE -- requirements
Module: multi_fifo_rr_merge

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bits per entry.
REQ-002 Parameter DEPTH, default 8, entries per channel; power of two, 2..256.
REQ-003 Parameter CHANNELS, default 4, number of input queues; 2..16.
REQ-004 Parameter PRIO_MODE, default 0, 0 = round-robin merge, 1 = fixed priority (channel 0 highest).
REQ-005 Derived widths SHALL be CW = $clog2(CHANNELS) and UW = $clog2(DEPTH)+1.
REQ-006 Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  CHANNELS  per-channel queue flush.
- push_i  in  CHANNELS  per-channel push strobe.
- data_i  in  CHANNELS*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- full_o  out  CHANNELS  channel c holds DEPTH entries.
- empty_o  out  CHANNELS  channel c holds 0 entries.
- usage_o  out  CHANNELS*UW  entry count of channel c at [c*UW +: UW].
- valid_o  out  1  at least one channel non-empty.
- data_o  out  DATA_WIDTH  head entry of the selected channel.
- sel_o  out  CW  index of the selected channel.
- pop_i  in  1  consume the head of the selected channel.

Function
REQ-007 Each channel SHALL be an independent circular FIFO with read pointer, write pointer and UW-bit count; pointers wrap from DEPTH-1 to 0.
REQ-008 full_o, empty_o and usage_o SHALL be decoded from registered counts only (no combinational path from push_i/pop_i/flush_i).
REQ-009 Push on channel c with full_o[c]=1 SHALL be dropped, with no state change, even if the same cycle pops channel c.
REQ-010 Accepted push SHALL write data_i slice at the write pointer; entry is visible at the head one cycle later (no fall-through).
REQ-011 pop_i with valid_o=0 SHALL be ignored.
REQ-012 pop_i with valid_o=1 SHALL advance the read pointer of channel sel_o and decrement its count.
REQ-013 Simultaneous accepted push and pop on one channel SHALL leave its count unchanged and advance both pointers.
REQ-014 flush_i[c] SHALL zero channel c pointers and count next cycle, overriding push_i[c] and any pop of channel c in that cycle.
REQ-015 valid_o SHALL equal OR of ~empty_o; when valid_o=0, data_o SHALL be 0 and sel_o SHALL be 0.
REQ-016 PRIO_MODE=1: sel_o SHALL be the lowest-index non-empty channel.
REQ-017 PRIO_MODE=0: a CW-bit register last_q SHALL hold the index of the last popped channel; sel_o SHALL be the first non-empty channel scanning last_q+1, last_q+2, ... modulo CHANNELS, ending at last_q.
REQ-018 last_q SHALL load sel_o on every cycle with pop_i=1 and valid_o=1 (including when the popped channel is flushed that cycle), and hold otherwise.
REQ-019 sel_o/data_o are combinational from registered state and MAY change between pops as channels fill; the consumer samples them in the pop cycle.
REQ-020 Every non-empty channel SHALL be granted within CHANNELS pops in PRIO_MODE=0.
REQ-021 Storage SHALL be uninitialised RAM; only pointers, counts and last_q are reset.

Reset
REQ-022 With rst_i=1 at a clock edge, all counts and pointers SHALL become 0 and last_q SHALL become CHANNELS-1, regardless of push_i, pop_i, flush_i.
REQ-023 After reset: empty_o all 1, full_o all 0, usage_o all 0, valid_o 0, data_o 0, sel_o 0.
REQ-024 Reset asserted mid-operation SHALL discard all queued entries; first post-reset grant in PRIO_MODE=0 is the lowest-index non-empty channel.

Verification
REQ-025 Defaults, reset, push A0 on ch0 and B0 on ch2 same cycle -> next cycle valid_o=1, sel_o=0, data_o=A0; pop -> sel_o=2, data_o=B0; pop -> valid_o=0.
REQ-026 Fill ch1 with 8 pushes (0x10..0x17) -> full_o[1]=1, usage=8; 9th push 0x18 plus simultaneous pop -> usage 7, 0x18 never appears; drain yields 0x11..0x17 in order with pointer wrap.
REQ-027 RR fairness: all 4 channels hold 3 entries, pop every cycle -> sel_o sequence 0,1,2,3,0,1,2,3,0,1,2,3.
REQ-028 PRIO_MODE=1, ch0 and ch3 each 2 entries, pop every cycle, push ch0 each cycle -> sel_o stays 0 while ch0 non-empty; ch3 served only after ch0 drains.
REQ-029 Flush ch2 holding 5 entries while pop_i=1 and sel_o=2 -> next cycle usage ch2=0, empty_o[2]=1, last_q=2; same-cycle push on ch2 dropped.
REQ-030 rst_i asserted with ch0/ch1 partially full and pop_i=1 -> next cycle all REQ-023 values hold, then pushes on ch1 and ch0 -> first grant sel_o=0.
